// File: rtl/xdemux4_seq_if.sv
// xdemux4_seq_if: control, configuration and data bundle for the sequenced 1-to-4 demultiplexer
// master: drives running_i, run_i, in0_i, sel_i, mode_i, delay_i, period_i, iter_i
// slave:  drives done_o, out0_o..out3_o, strb_o
interface xdemux4_seq_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              running_i;
   logic              run_i;
   logic              done_o;
   logic              mode_i;
   logic [1:0]        sel_i;
   logic [3:0]        strb_o;
   logic [CNT_W-1:0]  delay_i;
   logic [CNT_W-1:0]  period_i;
   logic [CNT_W-1:0]  iter_i;
   logic [DATA_W-1:0] in0_i;
   logic [DATA_W-1:0] out0_o;
   logic [DATA_W-1:0] out1_o;
   logic [DATA_W-1:0] out2_o;
   logic [DATA_W-1:0] out3_o;
   modport master (
      output running_i, run_i, in0_i, sel_i, mode_i, delay_i, period_i, iter_i,
      input  done_o, out0_o, out1_o, out2_o, out3_o, strb_o
   );
   modport slave (
      input  running_i, run_i, in0_i, sel_i, mode_i, delay_i, period_i, iter_i,
      output done_o, out0_o, out1_o, out2_o, out3_o, strb_o
   );
endinterface

// File: rtl/xdemux4_seq.sv
// xdemux4_seq: sequenced 1-to-4 registered demux, static or round-robin steering of one input stream
// clk_i: clock; rst_i: asynchronous active-high reset
// bus (slave): run/running control, sel/mode/delay/period/iter configuration,
//              in0 input stream, out0..out3 registered outputs, one-hot strb, done
module xdemux4_seq #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input logic          clk_i,
   input logic          rst_i,
   xdemux4_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   state_t            state;
   state_t            nxt;
   logic [1:0]        cur;
   logic              mode_q;
   logic [CNT_W-1:0]  dcnt;
   logic [CNT_W-1:0]  icnt;
   logic [CNT_W-1:0]  pcnt;
   logic [CNT_W-1:0]  per_q;
   logic [DATA_W-1:0] out_q [4];
   logic [3:0]        strb_q;
   logic              done_q;
   logic              cap;
   logic              wrap;
   // run_i always wins so a restart issued on the last capture keeps the block busy
   always_comb begin
      cap  = state == ACTIVE && bus.running_i;
      wrap = mode_q && pcnt + ONE == per_q;
      nxt  = bus.run_i ? (bus.iter_i == '0 ? IDLE : bus.delay_i != '0 ? DELAY : ACTIVE)
           : state == DELAY && bus.running_i && dcnt == ONE ? ACTIVE
           : cap && icnt == ONE ? IDLE
           : state;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         cur    <= '0;
         mode_q <= 1'b0;
         dcnt   <= '0;
         icnt   <= '0;
         pcnt   <= '0;
         per_q  <= '0;
         strb_q <= '0;
         done_q <= 1'b1;
         for (int k = 0; k < 4; k++) out_q[k] <= '0;
      end else begin
         strb_q <= cap ? 4'b0001 << cur : 4'b0000;
         done_q <= nxt == IDLE;
         if (cap) out_q[cur] <= bus.in0_i;
         if (bus.run_i) begin
            cur    <= bus.sel_i;
            mode_q <= bus.mode_i;
            per_q  <= bus.period_i == '0 ? ONE : bus.period_i;
            icnt   <= bus.iter_i;
            pcnt   <= '0;
            dcnt   <= bus.delay_i;
         end else begin
            if (state == DELAY && bus.running_i) dcnt <= dcnt - ONE;
            if (cap) begin
               icnt <= icnt - ONE;
               pcnt <= wrap ? '0 : pcnt + ONE;
               cur  <= cur + (wrap ? 2'd1 : 2'd0);
            end
         end
      end
   assign bus.out0_o = out_q[0];
   assign bus.out1_o = out_q[1];
   assign bus.out2_o = out_q[2];
   assign bus.out3_o = out_q[3];
   assign bus.strb_o = strb_q;
   assign bus.done_o = done_q;
endmodule

// File: tb/tb_xdemux4_seq.sv
// tb_xdemux4_seq: scoreboard bench for xdemux4_seq, directed steps with a strobe-driven checker
module tb_xdemux4_seq;
   typedef struct {
      logic [1:0]  p;
      logic [31:0] d;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cmp = 0;
   int          mis = 0;
   exp_t        q[$];
   exp_t        e;
   logic [31:0] exp_out [4];
   xdemux4_seq_if #(.DATA_W(32), .CNT_W(16)) bus ();
   xdemux4_seq #(.DATA_W(32), .CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      cmp++;
      assert (obs === exp) else begin
         mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic push(input logic [1:0] p, input logic [31:0] d);
      exp_t x;
      x.p = p;
      x.d = d;
      q.push_back(x);
   endtask
   task automatic run_cfg(input logic [1:0] sel, input logic mode, input logic [15:0] dly,
                          input logic [15:0] per, input logic [15:0] n);
      bus.sel_i    = sel;
      bus.mode_i   = mode;
      bus.delay_i  = dly;
      bus.period_i = per;
      bus.iter_i   = n;
      bus.run_i    = 1'b1;
      tick();
      bus.run_i    = 1'b0;
   endtask
   // every strobe must match the oldest queued word; all four outputs must track the model
   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) exp_out[k] = '0;
      end else begin
         if (bus.strb_o != 4'b0000) begin
            check("sb_pending", 128'(q.size() != 0), 128'(1));
            if (q.size() != 0) begin
               e = q.pop_front();
               check("strb_port", 128'(bus.strb_o), 128'(4'b0001 << e.p));
               exp_out[e.p] = e.d;
            end
         end
         check("outs", {bus.out3_o, bus.out2_o, bus.out1_o, bus.out0_o},
               {exp_out[3], exp_out[2], exp_out[1], exp_out[0]});
      end
   end
   initial begin
      bus.running_i = 1'b1;
      bus.run_i     = 1'b0;
      bus.in0_i     = '0;
      bus.sel_i     = '0;
      bus.mode_i    = 1'b0;
      bus.delay_i   = '0;
      bus.period_i  = '0;
      bus.iter_i    = '0;
      tick();
      tick();
      check("rst_done", 128'(bus.done_o), 128'(1));
      check("rst_strb", 128'(bus.strb_o), 128'(0));
      check("rst_outs", {bus.out3_o, bus.out2_o, bus.out1_o, bus.out0_o}, 128'(0));
      rst = 1'b0;
      tick();
      // static, sel 2, no delay, three words
      run_cfg(2'd2, 1'b0, 16'd0, 16'd0, 16'd3);
      check("t1_done_c1", 128'(bus.done_o), 128'(0));
      bus.in0_i = 32'hA; push(2'd2, 32'hA);
      tick();
      check("t1_strb_c2", 128'(bus.strb_o), 128'(4'b0100));
      check("t1_out2_c2", 128'(bus.out2_o), 128'(32'hA));
      bus.in0_i = 32'hB; push(2'd2, 32'hB);
      tick();
      bus.in0_i = 32'hC; push(2'd2, 32'hC);
      tick();
      check("t1_done_c4", 128'(bus.done_o), 128'(1));
      check("t1_out2_c4", 128'(bus.out2_o), 128'(32'hC));
      bus.in0_i = 32'hDEAD;
      tick();
      check("t1_strb_idle", 128'(bus.strb_o), 128'(0));
      check("t1_sb_empty", 128'(q.size()), 128'(0));
      // rotate from port 3, two words per port, wraps 3 -> 0 -> 1
      run_cfg(2'd3, 1'b1, 16'd0, 16'd2, 16'd6);
      for (int i = 1; i <= 6; i++) begin
         bus.in0_i = 32'(i);
         push(2'((3 + (i - 1) / 2) % 4), 32'(i));
         tick();
      end
      check("t2_done", 128'(bus.done_o), 128'(1));
      check("t2_strb_last", 128'(bus.strb_o), 128'(4'b0010));
      check("t2_out3", 128'(bus.out3_o), 128'(2));
      check("t2_out0", 128'(bus.out0_o), 128'(4));
      tick();
      check("t2_sb_empty", 128'(q.size()), 128'(0));
      // delay 3, two words, two stalled cycles after the first capture
      run_cfg(2'd1, 1'b0, 16'd3, 16'd0, 16'd2);
      bus.in0_i = 32'hBAD;
      for (int c = 1; c <= 3; c++) begin
         check("t3_delay_strb", 128'(bus.strb_o), 128'(0));
         check("t3_delay_done", 128'(bus.done_o), 128'(0));
         tick();
      end
      bus.in0_i = 32'h11; push(2'd1, 32'h11);
      tick();
      check("t3_strb_c5", 128'(bus.strb_o), 128'(4'b0010));
      bus.running_i = 1'b0;
      bus.in0_i = 32'h99;
      tick();
      check("t3_strb_c6", 128'(bus.strb_o), 128'(0));
      tick();
      check("t3_strb_c7", 128'(bus.strb_o), 128'(0));
      check("t3_done_c7", 128'(bus.done_o), 128'(0));
      bus.running_i = 1'b1;
      bus.in0_i = 32'h22; push(2'd1, 32'h22);
      tick();
      check("t3_strb_c8", 128'(bus.strb_o), 128'(4'b0010));
      check("t3_done_c8", 128'(bus.done_o), 128'(1));
      check("t3_out1_c8", 128'(bus.out1_o), 128'(32'h22));
      tick();
      // empty run
      run_cfg(2'd0, 1'b0, 16'd0, 16'd0, 16'd0);
      for (int c = 0; c < 3; c++) begin
         check("t4_empty_done", 128'(bus.done_o), 128'(1));
         check("t4_empty_strb", 128'(bus.strb_o), 128'(0));
         tick();
      end
      // period 0 acts as 1: ports 0,1,2,3,0
      run_cfg(2'd0, 1'b1, 16'd0, 16'd0, 16'd5);
      for (int i = 1; i <= 5; i++) begin
         bus.in0_i = 32'h40 + 32'(i);
         push(2'((i - 1) % 4), 32'h40 + 32'(i));
         tick();
      end
      check("t4_p0_done", 128'(bus.done_o), 128'(1));
      check("t4_p0_strb", 128'(bus.strb_o), 128'(4'b0001));
      tick();
      check("t4_sb_empty", 128'(q.size()), 128'(0));
      // restart on item 2 of 4: item 2 still lands on port 0, later words go to port 1
      run_cfg(2'd0, 1'b0, 16'd0, 16'd0, 16'd4);
      bus.in0_i = 32'h51; push(2'd0, 32'h51);
      tick();
      bus.in0_i = 32'h52; push(2'd0, 32'h52);
      bus.sel_i = 2'd1; bus.iter_i = 16'd2; bus.run_i = 1'b1;
      tick();
      bus.run_i = 1'b0;
      check("t5_done_restart", 128'(bus.done_o), 128'(0));
      bus.in0_i = 32'h53; push(2'd1, 32'h53);
      tick();
      bus.in0_i = 32'h54; push(2'd1, 32'h54);
      tick();
      check("t5_done", 128'(bus.done_o), 128'(1));
      check("t5_out0_kept", 128'(bus.out0_o), 128'(32'h52));
      check("t5_out1", 128'(bus.out1_o), 128'(32'h54));
      tick();
      check("t5_sb_empty", 128'(q.size()), 128'(0));
      // asynchronous reset between clock edges in ACTIVE
      run_cfg(2'd3, 1'b0, 16'd0, 16'd0, 16'd4);
      bus.in0_i = 32'h61; push(2'd3, 32'h61);
      tick();
      bus.in0_i = 32'h62; push(2'd3, 32'h62);
      tick();
      check("t6_pre_out3", 128'(bus.out3_o), 128'(32'h62));
      bus.in0_i = 32'h63;
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_outs", {bus.out3_o, bus.out2_o, bus.out1_o, bus.out0_o}, 128'(0));
      check("t6_async_done", 128'(bus.done_o), 128'(1));
      check("t6_async_strb", 128'(bus.strb_o), 128'(0));
      q.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("t6_post_done", 128'(bus.done_o), 128'(1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end
endmodule

// File: doc/xdemux4_seq.md
# xdemux4_seq

Sequenced 1-to-4 registered demultiplexer for the Versat datapath, the distributing counterpart of the 4-to-1 selector units. It captures a single input stream and steers each word to one of four registered outputs, either to a fixed port or rotating round-robin every `period_i` words. Fixed items count and start delay are set per run, and `done_o` reports completion to the Versat controller.

## Interface
- `DATA_W`, 32, data word width
- `CNT_W`, 16, width of the `delay_i`, `period_i` and `iter_i` counters

- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `running_i`  in  1  global run enable; low freezes all counters and suppresses capture
- `run_i`  in  1  start pulse; loads configuration and starts a run
- `done_o`  out  1  registered; high when idle or run complete
- `in0_i`  in  DATA_W  input data stream
- `out0_o`..`out3_o`  out  DATA_W each  registered outputs; each holds its value until next written
- `strb_o`  out  4  registered one-hot; bit k high in the cycle a new word first appears on `outk_o`
- `sel_i`  in  2  start port (static target in mode 0)
- `mode_i`  in  1  0 = static, 1 = rotate
- `delay_i`  in  CNT_W  enabled cycles to skip before the first capture
- `period_i`  in  CNT_W  words per port before advancing in rotate mode; 0 is treated as 1
- `iter_i`  in  CNT_W  total words to route; 0 means an empty run

## Operation
- FSM states: IDLE, DELAY, ACTIVE.
- IDLE: `done_o`=1, `strb_o`=0.
  - On `run_i`=1, latch `sel_i`, `mode_i`, `period_i` and `iter_i`, and load the delay count.
  - Next state is DELAY if `delay_i`>0, else ACTIVE.
  - If `iter_i`=0, stay IDLE and keep `done_o`=1.
- DELAY: the delay counter decrements only on cycles with `running_i`=1. When it reaches 0, go to ACTIVE.
- ACTIVE: each cycle with `running_i`=1:
  - Register `in0_i` into `out[cur]` and set `strb_o`=onehot(cur).
  - Decrement the item counter and increment the period counter.
  - Rotate mode: when the period counter reaches the latched period, reset it and set cur = cur+1 mod 4 (3 wraps to 0).
  - Static mode: cur stays at the latched `sel_i`.
  - The last item (item counter = 1) is captured, then the FSM returns to IDLE.
- `running_i`=0 in any state: counters, cur and outputs hold, and `strb_o`=0.
- `run_i` while in DELAY or ACTIVE: restart. Reload all configuration, reset the counters and set cur = new `sel_i`. Output values are kept.
- `run_i` and the last capture in the same cycle: the capture completes and the restart takes effect, so `done_o` stays low.
- Non-selected outputs never change.

## Timing
- Reset values: `out0_o`..`out3_o`=0, `strb_o`=0, `done_o`=1, FSM=IDLE, cur=0, all counters 0.
- Reset asserted mid-run aborts immediately to the reset values.
- Let cycle 0 be the cycle in which `run_i` is sampled, with `running_i` held high.
  - `done_o` is low from cycle 1.
  - With delay D, the input is first sampled in cycle D+1 and appears on the output (with strobe) in cycle D+2.
  - Item N is sampled in cycle D+N and appears in cycle D+N+1.
  - `done_o` returns high in cycle D+N+1.
- Each cycle with `running_i` low inserted into the run extends all later events by 1 cycle.
- Latency from input to output is 1 cycle. Throughput is 1 word per enabled cycle.

## Test plan
- Reset, then static mode: `sel_i`=2, D=0, N=3, input 0xA,0xB,0xC in cycles 1..3.
  - Expect `out2_o`=0xA,0xB,0xC in cycles 2..4 with `strb_o`=4'b0100.
  - Other outputs stay 0. `done_o` rises in cycle 4.
- Rotate mode: `sel_i`=3, period=2, N=6, input 1..6.
  - Expect `out3_o`←1,2, then `out0_o`←3,4, then `out1_o`←5,6 (wrap 3→0).
  - `strb_o` goes 1000,1000,0001,0001,0010,0010.
- Delay and stall: D=3, N=2, `running_i` dropped for 2 cycles after the first capture.
  - Expect first output in cycle 5, second in cycle 8, `done_o` high in cycle 8.
  - No strobe during the stall.
- Edge configs: `iter_i`=0 keeps `done_o`=1 with no strobes. `period_i`=0 behaves like 1 (ports 0,1,2,3,0 for N=5 from `sel_i`=0).
- Restart mid-run with `run_i` at item 2 of 4, new `sel_i`=1, static mode: prior outputs are retained and the next word goes to `out1_o`.
- Async reset asserted mid-ACTIVE: all outputs go to 0 and `done_o`=1 with no clock edge needed.
